// File: rtl/tt_um_koggestone_sub8_pkg.sv
// tt_um_koggestone_sub8_pkg: FSM state encoding and control/status bit positions
package tt_um_koggestone_sub8_pkg;
    typedef enum logic [1:0] {IDLE, PG, SUM, DONE} state_t;
    localparam int IN_LOAD_A = 0;
    localparam int IN_LOAD_B = 1;
    localparam int IN_START = 2;
    localparam int IN_OUT_SEL = 3;
    localparam int OUT_ZERO = 4;
    localparam int OUT_BORROW = 5;
    localparam int OUT_DONE = 6;
    localparam int OUT_BUSY = 7;
endpackage

// File: rtl/ks_prefix_cell.sv
// ks_prefix_cell: Kogge-Stone black cell combining a higher span with the span below it
module ks_prefix_cell (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g,
    output logic p
);
    assign g = g_hi | (p_hi & g_lo);
    assign p = p_hi & p_lo;
endmodule

// File: rtl/tt_um_koggestone_sub8.sv
// tt_um_koggestone_sub8: 8-bit A-B via a two-stage pipelined Kogge-Stone adder (A + ~B + 1)
module tt_um_koggestone_sub8
    import tt_um_koggestone_sub8_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    state_t state;
    logic [7:0] a, b, d, bn, g0, p0, g1, p1, g2, p2, g2_q, p2_q, g3, p3, d_next;
    logic borrow, zero, ovf, busy, done, ld_a, ld_b, ld, start, unused;
    assign ld_a = uio_in[IN_LOAD_A];
    assign ld_b = uio_in[IN_LOAD_B];
    assign ld = ld_a | ld_b;
    assign start = uio_in[IN_START];
    assign bn = ~b;
    assign p0 = a ^ bn;
    // cin=1 folded into bit 0: generate there becomes a0 | ~b0
    assign g0 = (a & bn) | {7'b0, p0[0]};
    for (genvar i = 0; i < 8; i++) begin : g_net
        if (i >= 1) begin : g_l1
            ks_prefix_cell u_c (.g_hi(g0[i]), .p_hi(p0[i]), .g_lo(g0[i-1]), .p_lo(p0[i-1]), .g(g1[i]), .p(p1[i]));
        end else begin : g_b1
            assign g1[i] = g0[i];
            assign p1[i] = p0[i];
        end
        if (i >= 2) begin : g_l2
            ks_prefix_cell u_c (.g_hi(g1[i]), .p_hi(p1[i]), .g_lo(g1[i-2]), .p_lo(p1[i-2]), .g(g2[i]), .p(p2[i]));
        end else begin : g_b2
            assign g2[i] = g1[i];
            assign p2[i] = p1[i];
        end
        if (i >= 4) begin : g_l3
            ks_prefix_cell u_c (.g_hi(g2_q[i]), .p_hi(p2_q[i]), .g_lo(g2_q[i-4]), .p_lo(p2_q[i-4]), .g(g3[i]), .p(p3[i]));
        end else begin : g_b3
            assign g3[i] = g2_q[i];
            assign p3[i] = p2_q[i];
        end
    end
    assign d_next = p0 ^ {g3[6:0], 1'b1};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a <= '0;
            b <= '0;
            g2_q <= '0;
            p2_q <= '0;
            d <= '0;
            borrow <= 1'b0;
            zero <= 1'b0;
            ovf <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (ld_a) a <= ui_in;
                    if (ld_b) b <= ui_in;
                    state <= ld ? IDLE : start ? PG : state;
                end
                PG: begin
                    g2_q <= g2;
                    p2_q <= p2;
                    state <= SUM;
                end
                SUM: begin
                    d <= d_next;
                    borrow <= ~g3[7];
                    zero <= d_next == 8'h00;
                    ovf <= (a[7] ^ b[7]) & (d_next[7] ^ a[7]);
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign busy = (state == PG) || (state == SUM);
    assign done = state == DONE;
    assign uo_out = uio_in[IN_OUT_SEL] ? {4'b0, ovf, zero, borrow, done} : d;
    always_comb begin
        uio_out = '0;
        uio_out[OUT_BUSY] = busy;
        uio_out[OUT_DONE] = done;
        uio_out[OUT_BORROW] = borrow;
        uio_out[OUT_ZERO] = zero;
    end
    assign uio_oe = 8'hF0;
    assign unused = &{1'b0, ena, uio_in[7:4], p3};
endmodule

// File: doc/tt_um_koggestone_sub8.md
TT_UM_KOGGESTONE_SUB8 -- requirements
Module: tt_um_koggestone_sub8

Interface
REQ-001 Parameter: none; width fixed at 8 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 ena  input  1  powered indication; ignored by logic.
REQ-005 ui_in  input  8  operand data bus.
REQ-006 uio_in  input  8  controls: [0] load_a, [1] load_b, [2] start, [3] out_sel; [7:4] ignored.
REQ-007 uo_out  output  8  out_sel=0: registered difference; out_sel=1: {4'b0, ovf, zero, borrow, done}.
REQ-008 uio_out  output  8  [7] busy, [6] done, [5] borrow, [4] zero; [3:0] driven 0.
REQ-009 uio_oe  output  8  constant 8'hF0.

Function
REQ-010 The block SHALL compute D = A - B mod 256 as A + ~B + 1 through an 8-bit Kogge-Stone prefix network with cin=1.
REQ-011 borrow SHALL be 1 iff A < B unsigned (carry-out of the prefix network inverted).
REQ-012 zero SHALL be 1 iff D == 0; ovf SHALL be 1 iff A[7] != B[7] and D[7] != A[7] (two's-complement overflow).
REQ-013 FSM states SHALL be IDLE, PG, SUM, DONE.
REQ-014 In IDLE or DONE, load_a=1 SHALL capture ui_in into A and load_b=1 SHALL capture ui_in into B on that edge; both high loads the same value into both.
REQ-015 Any load in DONE SHALL clear done and return to IDLE.
REQ-016 start=1 in IDLE or DONE with no load that cycle SHALL enter PG; start in the same cycle as a load SHALL be ignored (load wins).
REQ-017 PG SHALL register per-bit g/p after prefix levels 1 and 2 (distance 1, 2); next state SUM unconditionally.
REQ-018 SUM SHALL complete level 3 (distance 4), compute sum XOR, and register D, borrow, zero, ovf; next state DONE.
REQ-019 Latency: start sampled at edge N -> done=1 and valid results after edge N+2 (pipeline of two register stages).
REQ-020 busy SHALL be 1 exactly in PG and SUM; done SHALL be 1 exactly in DONE.
REQ-021 Loads and start while busy SHALL be ignored; A and B SHALL not change during PG/SUM.
REQ-022 Result registers SHALL hold their value until the next SUM state overwrites them; a new start from DONE re-runs on current A/B.
REQ-023 out_sel SHALL be a purely combinational mux on registered values (no added latency).

Reset
REQ-024 rst_n=0 SHALL asynchronously force state IDLE, A=B=0, D=0, borrow=0, zero=0, ovf=0, so busy=done=0 and uo_out=0.
REQ-025 Reset asserted in PG or SUM SHALL abort the operation; no done pulse follows after release.
REQ-026 Deassertion SHALL be synchronised by the design's clock edge; first state change no earlier than the first edge after release.

Structure
REQ-027 Shared package SHALL hold the FSM state encoding and uio_in/uio_out bit-position constants.
REQ-028 One sub-module ks_prefix_cell (black cell: G = Gi | Pi&Gprev, P = Pi&Pprev) SHALL be instantiated for every prefix node; grey/buffer nodes are wiring or that cell with P unused.
REQ-029 No latches; uio_out[3:0] and unused uo_out bits tied to 0.

Verification
REQ-030 A=0x05 via load_a, B=0x03 via load_b, start -> two edges later done=1, uo_out=0x02, borrow=0, zero=0, ovf=0.
REQ-031 A=0x03, B=0x05, start -> uo_out=0xFE, borrow=1, ovf=0; out_sel=1 -> uo_out=0x03.
REQ-032 A=0x80, B=0x01 -> D=0x7F, ovf=1, borrow=0; A=0x7F, B=0x7F -> D=0x00, zero=1.
REQ-033 start plus load_a same cycle in IDLE -> state stays IDLE, A updated; start asserted in PG -> ignored, single done, result unchanged.
REQ-034 rst_n pulsed low during SUM -> immediately busy=0, done=0, uo_out=0; no done after release.
REQ-035 Exhaustive 65536 A/B pairs against A-B reference model: D, borrow, zero, ovf all match; latency always 2 edges.
